// File: rtl/collision_arbiter.sv
// collision_arbiter: accumulates per-ball collision flags over a video frame and turns them into
// one-cycle event pulses at startOfFrame. Optional macro COLLISION_ROPE_RR_EN selects round-robin rope arbitration.
//
// state    | meaning
// IDLE_ACC | accumulating sticky collision flags for the current frame
// EVAL     | one cycle after startOfFrame; registered event pulses are visible
module collision_arbiter #(
    parameter int NUM_BALLS       = 3,
    parameter int TYPE_W          = 2,
    parameter int IMMORTAL_FRAMES = 60,
    localparam int IDX_W          = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_BALLS-1:0]        col_player_ball,
    input  logic [NUM_BALLS-1:0]        col_rope_ball,
    input  logic [NUM_BALLS*TYPE_W-1:0] col_ball_type,
    input  logic                       col_present,
    output logic                       player_hit,
    output logic                       rope_hit,
    output logic [IDX_W-1:0]           hit_ball_idx,
    output logic [TYPE_W-1:0]          hit_ball_type,
    output logic                       present_hit,
    output logic                       immortal
);

    localparam int CNT_W = (IMMORTAL_FRAMES > 0) ? $clog2(IMMORTAL_FRAMES + 1) : 1;

    typedef enum logic {IDLE_ACC, EVAL} state_t;

    state_t                 state, state_nxt;
    logic [NUM_BALLS-1:0]   p_flags, r_flags;
    logic                   pres_flag;
    logic [TYPE_W-1:0]      type_lat [NUM_BALLS];
    logic [CNT_W-1:0]       imm_cnt, imm_cnt_nxt;

    logic                   player_hit_nxt, rope_hit_nxt, present_hit_nxt;
    logic [IDX_W-1:0]       idx_nxt;
    logic [TYPE_W-1:0]      type_nxt;

    logic                   win_any;
    logic [IDX_W-1:0]       win_idx;
    logic [TYPE_W-1:0]      win_type;

`ifdef COLLISION_ROPE_RR_EN
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;

    // Two passes: first the indices at or above the pointer, then wrap to the bottom.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        win_type = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!win_any && r_flags[i] && i >= int'(rr_ptr)) begin
                win_any  = 1'b1;
                win_idx  = IDX_W'(i);
                win_type = type_lat[i];
            end
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!win_any && r_flags[i]) begin
                win_any  = 1'b1;
                win_idx  = IDX_W'(i);
                win_type = type_lat[i];
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (state_nxt == EVAL && win_any)
            rr_ptr_nxt = (int'(win_idx) == NUM_BALLS - 1) ? '0 : win_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rr_ptr <= '0;
        else         rr_ptr <= rr_ptr_nxt;
    end
`else
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        win_type = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!win_any && r_flags[i]) begin
                win_any  = 1'b1;
                win_idx  = IDX_W'(i);
                win_type = type_lat[i];
            end
        end
    end
`endif

    always_comb begin
        state_nxt       = IDLE_ACC;
        player_hit_nxt  = 1'b0;
        rope_hit_nxt    = 1'b0;
        present_hit_nxt = 1'b0;
        imm_cnt_nxt     = imm_cnt;
        idx_nxt         = hit_ball_idx;
        type_nxt        = hit_ball_type;
        case (state)
            IDLE_ACC: if (startOfFrame) state_nxt = EVAL;
            EVAL:     if (startOfFrame) state_nxt = EVAL;
            default:  state_nxt = IDLE_ACC;
        endcase
        if (state_nxt == EVAL) begin
            if (win_any) begin
                rope_hit_nxt = 1'b1;
                idx_nxt      = win_idx;
                type_nxt     = win_type;
            end
            // Player flags are ignored while immortal; the window is never extended.
            if (|p_flags && imm_cnt == '0) begin
                player_hit_nxt = 1'b1;
                imm_cnt_nxt    = CNT_W'(IMMORTAL_FRAMES);
            end else if (imm_cnt != '0) begin
                imm_cnt_nxt = imm_cnt - CNT_W'(1);
            end
            present_hit_nxt = pres_flag;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE_ACC;
            player_hit    <= 1'b0;
            rope_hit      <= 1'b0;
            present_hit   <= 1'b0;
            hit_ball_idx  <= '0;
            hit_ball_type <= '0;
            imm_cnt       <= '0;
            p_flags       <= '0;
            r_flags       <= '0;
            pres_flag     <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) type_lat[i] <= '0;
        end else begin
            state         <= state_nxt;
            player_hit    <= player_hit_nxt;
            rope_hit      <= rope_hit_nxt;
            present_hit   <= present_hit_nxt;
            hit_ball_idx  <= idx_nxt;
            hit_ball_type <= type_nxt;
            imm_cnt       <= imm_cnt_nxt;
            // The boundary cycle's inputs start the new frame.
            if (startOfFrame) begin
                p_flags   <= col_player_ball;
                r_flags   <= col_rope_ball;
                pres_flag <= col_present;
            end else begin
                p_flags   <= p_flags | col_player_ball;
                r_flags   <= r_flags | col_rope_ball;
                pres_flag <= pres_flag | col_present;
            end
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (col_rope_ball[i] && (startOfFrame || !r_flags[i]))
                    type_lat[i] <= col_ball_type[i*TYPE_W +: TYPE_W];
            end
        end
    end

    assign immortal = (imm_cnt != '0);

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: table of whole frames checked through a scoreboard queue,
// plus hand-written reset and no-frame-strobe sequences.
module tb_collision_arbiter;

    localparam int N  = 3;
    localparam int TW = 2;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            startOfFrame = 1'b0;
    logic [N-1:0]    col_player_ball = '0;
    logic [N-1:0]    col_rope_ball = '0;
    logic [N*TW-1:0] col_ball_type = '0;
    logic            col_present = 1'b0;
    logic            player_hit, rope_hit, present_hit, immortal;
    logic [IW-1:0]   hit_ball_idx;
    logic [TW-1:0]   hit_ball_type;

    collision_arbiter #(.NUM_BALLS(N), .TYPE_W(TW), .IMMORTAL_FRAMES(3)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .col_player_ball(col_player_ball), .col_rope_ball(col_rope_ball),
        .col_ball_type(col_ball_type), .col_present(col_present),
        .player_hit(player_hit), .rope_hit(rope_hit),
        .hit_ball_idx(hit_ball_idx), .hit_ball_type(hit_ball_type),
        .present_hit(present_hit), .immortal(immortal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pb;
        logic [2:0] rb;
        logic [5:0] ty;
        logic       pres;
        logic [2:0] sof_rb;
        logic       e_ph, e_rh, e_pr, e_imm;
        logic [1:0] e_idx, e_ty;
    } vec_t;

    typedef struct {
        logic       ph, rh, pr, imm;
        logic [1:0] idx, ty;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(logic [2:0] pb, logic [2:0] rb, logic [5:0] ty, logic pres,
                                logic [2:0] sof_rb, logic ph, logic rh, logic pr, logic imm,
                                logic [1:0] idx, logic [1:0] t);
        vec_t v;
        v.pb = pb; v.rb = rb; v.ty = ty; v.pres = pres; v.sof_rb = sof_rb;
        v.e_ph = ph; v.e_rh = rh; v.e_pr = pr; v.e_imm = imm; v.e_idx = idx; v.e_ty = t;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_player_hit"}, 32'(player_hit), 0);
        chk({tag, "_rope_hit"}, 32'(rope_hit), 0);
        chk({tag, "_present_hit"}, 32'(present_hit), 0);
        chk({tag, "_immortal"}, 32'(immortal), 0);
        chk({tag, "_idx"}, 32'(hit_ball_idx), 0);
        chk({tag, "_type"}, 32'(hit_ball_type), 0);
    endtask

    task automatic apply_vec(input int k, input vec_t v);
        exp_t e;
        string t;
        t = $sformatf("v%0d", k);
        col_player_ball = v.pb;
        col_rope_ball   = v.rb;
        col_ball_type   = v.ty;
        col_present     = v.pres;
        startOfFrame    = 1'b0;
        repeat (5) cycle();
        col_player_ball = '0;
        col_present     = 1'b0;
        col_rope_ball   = v.sof_rb;
        startOfFrame    = 1'b1;
        e.ph = v.e_ph; e.rh = v.e_rh; e.pr = v.e_pr; e.imm = v.e_imm; e.idx = v.e_idx; e.ty = v.e_ty;
        sb.push_back(e);
        cycle();
        startOfFrame  = 1'b0;
        col_rope_ball = '0;
        if (sb.size() == 0) begin
            chk({t, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({t, "_player_hit"}, 32'(player_hit), 32'(e.ph));
            chk({t, "_rope_hit"}, 32'(rope_hit), 32'(e.rh));
            chk({t, "_present_hit"}, 32'(present_hit), 32'(e.pr));
            chk({t, "_immortal"}, 32'(immortal), 32'(e.imm));
            chk({t, "_idx"}, 32'(hit_ball_idx), 32'(e.idx));
            chk({t, "_type"}, 32'(hit_ball_type), 32'(e.ty));
            cycle();
            chk({t, "_pulse_width"}, 32'({player_hit, rope_hit, present_hit}), 0);
            chk({t, "_immortal_hold"}, 32'(immortal), 32'(e.imm));
            chk({t, "_idx_hold"}, 32'(hit_ball_idx), 32'(e.idx));
        end
    endtask

    initial begin
        // Frames:          pb      rb      types      pres sof_rb  ph rh pr imm idx type
        vecs[0] = mk(3'b000, 3'b110, 6'b01_10_00, 0, 3'b000, 0, 1, 0, 0, 2'd1, 2'd2);
`ifdef COLLISION_ROPE_RR_EN
        vecs[1] = mk(3'b000, 3'b110, 6'b01_10_00, 0, 3'b000, 0, 1, 0, 0, 2'd2, 2'd1);
`else
        vecs[1] = mk(3'b000, 3'b110, 6'b01_10_00, 0, 3'b000, 0, 1, 0, 0, 2'd1, 2'd2);
`endif
        vecs[2] = mk(3'b010, 3'b100, 6'b11_00_00, 1, 3'b000, 1, 1, 1, 1, 2'd2, 2'd3);
        vecs[3] = mk(3'b001, 3'b000, 6'b00_00_00, 0, 3'b000, 0, 0, 0, 1, 2'd2, 2'd3);
        vecs[4] = mk(3'b010, 3'b000, 6'b00_00_00, 0, 3'b000, 0, 0, 0, 1, 2'd2, 2'd3);
        vecs[5] = mk(3'b100, 3'b000, 6'b00_00_00, 1, 3'b000, 0, 0, 1, 0, 2'd2, 2'd3);
        vecs[6] = mk(3'b001, 3'b000, 6'b00_00_00, 0, 3'b000, 1, 0, 0, 1, 2'd2, 2'd3);
        vecs[7] = mk(3'b000, 3'b000, 6'b00_00_10, 0, 3'b001, 0, 0, 0, 1, 2'd2, 2'd3);
        vecs[8] = mk(3'b000, 3'b000, 6'b11_11_11, 0, 3'b000, 0, 1, 0, 1, 2'd0, 2'd2);

        repeat (3) cycle();
        chk_all_zero("reset");
        resetN = 1'b1;
        cycle();

        for (int k = 0; k < 9; k++) apply_vec(k, vecs[k]);

        // Reset while immortal with every flag set.
        col_player_ball = 3'b001;
        col_rope_ball   = 3'b001;
        col_present     = 1'b1;
        col_ball_type   = 6'b00_00_11;
        repeat (3) cycle();
        chk("pre_reset_immortal", 32'(immortal), 1);
        resetN = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        col_player_ball = '0;
        col_rope_ball   = '0;
        col_present     = 1'b0;
        repeat (2) cycle();
        resetN = 1'b1;
        repeat (2) cycle();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
        chk_all_zero("post_reset_eval");

        // Activity with no frame strobe never produces a pulse.
        col_player_ball = 3'b111;
        col_rope_ball   = 3'b111;
        col_present     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk($sformatf("no_sof_c%0d", c), 32'({player_hit, rope_hit, present_hit, immortal}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Frame-based collision arbiter for N balls, placed between the per-ball collision detectors and the game controller. It accumulates pixel-level collision flags over a video frame and evaluates them once per frame at `startOfFrame`. It then emits single-cycle event pulses with the winning ball index and type, and runs the post-hit immortality window internally.

## Interface
Parameters:
- `NUM_BALLS`, 3: number of ball channels, 1..16
- `TYPE_W`, 2: width of each ball's type field
- `IMMORTAL_FRAMES`, 60: frames of immortality after an accepted player hit; 0 disables immortality
- `IDX_W`: derived as max(1, $clog2(NUM_BALLS))

Ports:
- `clk` in 1: system clock
- `resetN` in 1: asynchronous active-low reset; all state cleared while low
- `startOfFrame` in 1: one-cycle strobe per frame
- `col_player_ball` in NUM_BALLS: per-ball player/ball pixel overlap
- `col_rope_ball` in NUM_BALLS: per-ball rope/ball pixel overlap
- `col_ball_type` in NUM_BALLS*TYPE_W: ball i type at bits [i*TYPE_W +: TYPE_W]
- `col_present` in 1: player/present pixel overlap
- `player_hit` out 1: one-cycle pulse, accepted player/ball collision
- `rope_hit` out 1: one-cycle pulse, rope hit a ball
- `hit_ball_idx` out IDX_W: index of the ball granted for `rope_hit`, held until the next grant
- `hit_ball_type` out TYPE_W: type of the granted ball, latched during the frame, held until the next grant
- `present_hit` out 1: one-cycle pulse, present collected
- `immortal` out 1: high while the immortality counter is nonzero

## Operation
- Per-frame sticky flags: `p_flags[N]`, `r_flags[N]`, `pres_flag`, and a type latch per ball.
- Each flag sets on any cycle its input is high.
- Each type latch captures `col_ball_type` on the first cycle that ball's `r_flags` bit sets within the frame.
- Evaluation happens on the cycle `startOfFrame` is high, using the flag values before that cycle's inputs are merged.
- In the evaluation cycle, flags clear and then merge that cycle's inputs, so the boundary cycle belongs to the new frame.
- Rope arbitration: if any `r_flags` bit is set, the lowest set index wins. Drive `rope_hit`=1 with the winning `hit_ball_idx` and `hit_ball_type`. Losing rope hits that frame are discarded.
- Player hit, with counter `imm_cnt` (width $clog2(IMMORTAL_FRAMES+1), min 1):
  - If any `p_flags` bit is set and `imm_cnt`==0: `player_hit`=1 and load `imm_cnt`=IMMORTAL_FRAMES.
  - Else if `imm_cnt`>0: decrement `imm_cnt`. Player flags are ignored; no extension.
- `present_hit` = `pres_flag`, independent of immortality.
- Player, rope and present events may all pulse in the same evaluation.
- FSM per frame: IDLE_ACC (accumulate) → EVAL (one cycle, outputs registered) → IDLE_ACC. EVAL is entered only via `startOfFrame`.
- A `startOfFrame` arriving in the cycle immediately after EVAL is a legal back-to-back frame and is evaluated normally.

## Timing
- Latency: pulses are high in the cycle after `startOfFrame` is sampled high, for exactly one cycle.
- `immortal` updates in that same cycle.
- Reset values: `player_hit`, `rope_hit`, `present_hit`, `immortal`, `hit_ball_idx`, `hit_ball_type` all 0. Flags, `imm_cnt` and the round-robin pointer are also 0.
- Reset asserted mid-frame discards all accumulated flags and ends immortality immediately.
- Without any `startOfFrame`, no pulses are ever produced.

## Configuration
- Macro `COLLISION_ROPE_RR_EN`, defined: rope arbitration is round-robin.
  - Pointer `rr_ptr` starts at 0.
  - The grant goes to the first set flag at index ≥ `rr_ptr`, wrapping modulo NUM_BALLS.
  - After a grant, `rr_ptr` = (idx+1) mod NUM_BALLS.
  - `rr_ptr` is unchanged on frames without a rope hit.
- Macro undefined: fixed lowest-index priority and no pointer register.

## Test plan
- Reset, then `col_rope_ball`=3'b110 for 5 cycles with ball1 type=2 and ball2 type=1, then `startOfFrame` → next cycle `rope_hit`=1, `hit_ball_idx`=1, `hit_ball_type`=2. With `COLLISION_ROPE_RR_EN` and a repeat of the same pattern next frame: `hit_ball_idx`=2.
- IMMORTAL_FRAMES=3, player hit on ball0 in frame 0 → `player_hit` pulse and `immortal`=1. Player hits in frames 1–3 produce no pulse. `immortal` falls after the 3rd subsequent `startOfFrame`. A hit in frame 4 pulses again.
- `col_player_ball`, `col_rope_ball` and `col_present` all high in one frame → all three pulses in the same cycle after `startOfFrame`.
- `col_rope_ball[0]` high only on the cycle `startOfFrame` is high → no pulse for the current evaluation. `rope_hit` pulses at the following `startOfFrame`.
- Assert `resetN`=0 while `immortal`=1 with flags set → all outputs 0. The next `startOfFrame` after reset gives no pulses.
